wb_trace_buffer: RTL



---
 rtl/wb_trace_buffer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
//   Commit-trace capture for the MEM/WB stage. Each register-file write to a
//   non-zero destination is stamped with a free-running 16-bit cycle counter
//   and pushed into a circular FIFO, drained through a valid/ready port.
//
// Ports
//   clk, reset                 pipeline clock, async active-high reset
//   wwreg, wmtoreg, wdest,     MEM/WB write-back fields being observed
//   walu, wdo
//   arm, disarm, flush         single-cycle control pulses
//   rd_ready                   consumer accepts the head entry
//   rd_valid, rd_cycle,        head entry (all zero while FIFO is empty)
//   rd_reg, rd_value
//   count                      occupancy 0..DEPTH
//   overflow                   sticky drop indicator
//   state                      0 = IDLE, 1 = RUN, 2 = HALT
module wb_trace_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wwreg,
    input  logic              wmtoreg,
    input  logic [5:0]        wdest,
    input  logic [31:0]       walu,
    input  logic [31:0]       wdo,
    input  logic              arm,
    input  logic              disarm,
    input  logic              flush,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [15:0]       rd_cycle,
    output logic [4:0]        rd_reg,
    output logic [31:0]       rd_value,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [15:0]         cycle_q;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                ovf_q, ovf_d;

    logic [15:0]         mem_cyc [DEPTH];
    logic [4:0]          mem_reg [DEPTH];
    logic [31:0]         mem_val [DEPTH];

    logic                is_event, full, pop, capture, push, drop;
    logic [31:0]         wb_value;

    // Only the low five destination bits name an architectural register.
    logic                unused_wdest_hi;
    assign unused_wdest_hi = wdest[5];

    always_comb begin
        is_event = wwreg && (wdest[4:0] != 5'd0);
        wb_value = wmtoreg ? wdo : walu;
        full     = (count_q == FULL_CNT);
        pop      = (count_q != '0) && rd_ready;
        // Events coinciding with any control pulse are never captured; flush
        // additionally discards the pop of its cycle.
        capture  = (state_q == S_RUN) && is_event && !arm && !disarm && !flush;
        push     = capture && (!full || pop);
        drop     = capture && full && !pop;
    end

    always_comb begin
        state_d = state_q;
        if (disarm)
            state_d = S_IDLE;
        else if (arm)
            state_d = S_RUN;
        else if (flush && state_q == S_HALT)
            state_d = S_RUN;
        else if (drop)
            state_d = S_HALT;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | drop;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_q + 16'd1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; the read mux below hides stale contents.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_cyc[wr_ptr_q] <= cycle_q;
            mem_reg[wr_ptr_q] <= wdest[4:0];
            mem_val[wr_ptr_q] <= wb_value;
        end
    end

    always_comb begin
        rd_valid = (count_q != '0);
        rd_cycle = rd_valid ? mem_cyc[rd_ptr_q] : '0;
        rd_reg   = rd_valid ? mem_reg[rd_ptr_q] : '0;
        rd_value = rd_valid ? mem_val[rd_ptr_q] : '0;
        count    = count_q;
        overflow = ovf_q;
        state    = state_q;
    end

endmodule
